// File: rtl/cpu_pkg.sv
// Shared CPU types and sizing used by the fetch front end.
package cpu_pkg;

  localparam int XLEN     = 32;
  localparam int FB_DEPTH = 4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fb_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Fetch buffer: in-order FIFO of {pc, instr} between ifetch and decode, with flush-aware response dropping.
// Latency: a response is visible on dec_valid one cycle after resp_valid (no bypass).
// Backpressure: req_ok reserves a slot per in-flight request, so a response never finds the FIFO full.
module fetch_buffer #(
  parameter int XLEN  = cpu_pkg::XLEN,
  parameter int DEPTH = cpu_pkg::FB_DEPTH
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_fire,
  output logic            req_ok,
  input  logic            resp_valid,
  input  logic [XLEN-1:0] resp_pc,
  input  logic [XLEN-1:0] resp_data,
  input  logic            flush,
  output logic            dec_valid,
  input  logic            dec_ready,
  output logic [XLEN-1:0] dec_pc,
  output logic [XLEN-1:0] dec_instr
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  cpu_pkg::fb_entry_t mem [DEPTH];
  ptr_t               rd_ptr;
  ptr_t               wr_ptr;
  cnt_t               count;
  cnt_t               inflight;
  cnt_t               drop;
  logic [CW:0]        occupancy;
  logic               push;
  logic               pop;

  // Every outstanding request owns a slot, so occupancy counts both.
  assign occupancy = {1'b0, count} + {1'b0, inflight};
  assign req_ok    = occupancy < (CW+1)'(DEPTH);

  assign dec_valid = (count != '0);
  assign dec_pc    = mem[rd_ptr].pc;
  assign dec_instr = mem[rd_ptr].instr;

  assign push = resp_valid && (drop == '0) && !flush;
  assign pop  = dec_valid && dec_ready && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      inflight <= '0;
      drop     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (req_fire && !resp_valid) begin
        inflight <= inflight + cnt_t'(1);
      end else if (!req_fire && resp_valid) begin
        inflight <= inflight - cnt_t'(1);
      end

      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
        // A request fired alongside the flush belongs to the new path and is kept.
        drop   <= inflight - cnt_t'(resp_valid);
      end else begin
        if (resp_valid && (drop != '0)) begin
          drop <= drop - cnt_t'(1);
        end
        if (push) begin
          mem[wr_ptr] <= '{pc: resp_pc, instr: resp_data};
          wr_ptr      <= wr_ptr + ptr_t'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + ptr_t'(1);
        end
        if (push && !pop) begin
          count <= count + cnt_t'(1);
        end else if (pop && !push) begin
          count <= count - cnt_t'(1);
        end
      end
    end
  end

`ifndef SYNTHESIS
  a_resp_without_req: assert property (@(posedge clk) disable iff (!rst_n)
    resp_valid |-> (inflight != '0));
  a_fire_without_ok: assert property (@(posedge clk) disable iff (!rst_n)
    req_fire |-> req_ok);
  a_head_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (dec_valid && !dec_ready && !flush) |=> ($stable(dec_pc) && $stable(dec_instr)));
`endif

endmodule
